// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Runs the mem_req/mem_ack handshake with a timeout and rejects misaligned addresses locally.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        grant_d
);

  localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          rr_last_d;
  logic          pick_d, misaligned, timed_out, fin, fin_err;
  logic [31:0]   sel_addr, fin_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nx = misaligned ? RESP : WAIT;
      WAIT:    if (fin) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Data wins when it is the only requester or when fetch owned the last grant.
  always_comb begin
    pick_d     = d_req && (!i_req || !rr_last_d);
    sel_addr   = pick_d ? d_addr : i_addr;
    misaligned = (sel_addr[1:0] != 2'b00);
    timed_out  = (cnt == LAST);
    fin        = (state == WAIT) && (mem_ack || timed_out);
    fin_err    = !mem_ack;
    fin_data   = (mem_ack && !mem_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_d   <= 1'b0;
      rr_last_d <= ~DATA_FIRST;
      cnt       <= '0;
    end else begin
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
      i_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
      case (state)
        IDLE: if (i_req || d_req) begin
          grant_d   <= pick_d;
          rr_last_d <= pick_d;
          mem_we    <= pick_d && d_we;
          mem_be    <= pick_d ? d_be : 4'hF;
          mem_addr  <= sel_addr;
          mem_wdata <= pick_d ? d_wdata : '0;
          cnt       <= '0;
          if (misaligned) begin
            i_ack <= !pick_d;
            i_err <= !pick_d;
            d_ack <= pick_d;
            d_err <= pick_d;
          end else begin
            mem_req <= 1'b1;
          end
        end
        WAIT: if (fin) begin
          mem_req <= 1'b0;
          i_ack   <= !grant_d;
          i_err   <= !grant_d && fin_err;
          i_rdata <= grant_d ? '0 : fin_data;
          d_ack   <= grant_d;
          d_err   <= grant_d && fin_err;
          d_rdata <= grant_d ? fin_data : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the instruction-fetch requester (read-only) and the data/MEM-stage requester (read/write). Grants one transaction at a time with round-robin fairness and runs the memory req/ack handshake. Returns a registered one-cycle ack with read data to the winning requester. Guards against a hung memory with a timeout and rejects misaligned addresses without touching memory.

## Interface
- `TIMEOUT`, default 255: max cycles in WAIT without `mem_ack` before the transaction is aborted (≥1).
- `DATA_FIRST`, default 1: 1 means data wins the first contended arbitration after reset; 0 means fetch wins.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request, level, held until `i_ack`.
- `i_addr` in 32: fetch address.
- `i_ack` out 1: one-cycle fetch completion pulse.
- `i_rdata` out 32: fetch data, valid with `i_ack`.
- `i_err` out 1: fetch error, valid with `i_ack`.
- `d_req` in 1: data request, level, held until `d_ack`.
- `d_we` in 1: 1 = write.
- `d_be` in 4: byte enables (writes).
- `d_addr` in 32: data address.
- `d_wdata` in 32: write data.
- `d_ack` out 1: one-cycle data completion pulse.
- `d_rdata` out 32: read data, valid with `d_ack`; 0 for writes.
- `d_err` out 1: data error, valid with `d_ack`.
- `mem_req` out 1: memory request, held until `mem_ack` or timeout.
- `mem_we` out 1: memory write.
- `mem_be` out 4: memory byte enables; 4'hF for fetch.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_ack` in 1: one-cycle memory completion.
- `mem_rdata` in 32: memory read data, valid with `mem_ack`.
- `grant_d` out 1: owner of current/last transaction (1 = data).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Sample `i_req`/`d_req`.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port not granted last (round-robin pointer, updated on every grant).
  - On grant: latch address, we, be, wdata and owner into `grant_d`.
  - Granted address with `[1:0]` ≠ 0: go to RESP with error, no memory access.
  - Otherwise: go to WAIT, `mem_req`=1.
- WAIT:
  - `mem_req` and all memory outputs stay stable.
  - `mem_ack`: capture `mem_rdata` (0 if write), drop `mem_req`, go to RESP.
  - Timeout counter reaches `TIMEOUT` without ack: drop `mem_req`, go to RESP with err=1 and rdata=0.
- RESP:
  - Exactly one of `i_ack`/`d_ack` is high, with matching rdata and err.
  - Next state is always IDLE. This gives the requester the RESP edge to drop its req, so a stale req is never re-granted.
- Fetch transactions always use we=0, be=4'hF.
- `mem_ack` seen in IDLE or RESP is stray and ignored.
- A requester dropping req during WAIT is ignored; the transaction completes and the ack is still issued.
- Timeout counter width is $clog2(TIMEOUT+1). It clears on entry to WAIT and never wraps.

## Timing
- Reset (asynchronous, low) forces, immediately and regardless of state:
  - state IDLE, all outputs 0, `mem_req` dropped mid-transaction;
  - counter 0;
  - RR pointer set so the `DATA_FIRST` port wins first.
- Req high in IDLE cycle t: `mem_req` high from t+1.
- `mem_ack` at cycle t+1+L (L≥0): requester ack at t+2+L.
- Minimum req-to-ack is 2 cycles. Minimum issue interval is 3 cycles per transaction.
- Misaligned request: ack+err at t+1, no `mem_req`.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles (t+1 .. t+TIMEOUT), then ack+err at t+TIMEOUT+1.
- All outputs are registered; no combinational path from requester inputs or `mem_*` inputs to outputs.

## Test plan
- **Reset values:** reset low mid-WAIT → `mem_req`, acks and errs 0 immediately. After release, an idle bus shows no activity.
- **Fetch read:** `i_req`=1, `i_addr`=0x100, memory acks 1 cycle after `mem_req` with 0xCAFEF00D → `mem_addr`=0x100, be=F, we=0; `i_ack` pulse with `i_rdata`=0xCAFEF00D; no `d_ack`.
- **Contention:** `i_req` and `d_req` both held, `DATA_FIRST`=1 → grant order D, I, D, I. Each ack is a single cycle; no port is granted twice in a row while the other is waiting.
- **Data write:** `d_we`=1, be=4'b0011, addr 0x2000, wdata 0x1234 → memory outputs match and are stable across 5 wait cycles; `d_ack` with `d_rdata`=0, `d_err`=0.
- **Misaligned:** `d_addr`=0x2002 → `d_ack` and `d_err` at t+1; `mem_req` never asserts.
- **Timeout:** `TIMEOUT`=4, memory never acks → `mem_req` high exactly 4 cycles, then `i_ack`+`i_err`, `i_rdata`=0. A later stray `mem_ack` in IDLE is ignored.
